// File: rtl/pwm_reg_pkg.sv
// Shared constants, frame layout and FSM encoding for the PWM register controller.
package pwm_reg_pkg;

  localparam int unsigned NUM_REGS = 5;
  localparam int unsigned BANK_AW  = 3;

  localparam int unsigned ADDR_EN_OUT_LO = 0;
  localparam int unsigned ADDR_EN_OUT_HI = 1;
  localparam int unsigned ADDR_EN_PWM_LO = 2;
  localparam int unsigned ADDR_EN_PWM_HI = 3;
  localparam int unsigned ADDR_DUTY      = 4;

  localparam int unsigned WR_BIT   = 15;
  localparam int unsigned ADDR_MSB = 14;
  localparam int unsigned ADDR_LSB = 8;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    STAGE
  } state_e;

endpackage

// File: rtl/pwm_shadow_bank.sv
// Shadow/active register pairs; shadow is copied to active atomically on a period boundary.
module pwm_shadow_bank
  import pwm_reg_pkg::*;
#(
  parameter bit IMMEDIATE = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_i,
  input  logic [BANK_AW-1:0]           wr_addr_i,
  input  logic [7:0]                   wr_data_i,
  input  logic                         period_end_i,
  output logic [NUM_REGS-1:0][7:0]     active_o,
  output logic                         pending_o
);

  logic [NUM_REGS-1:0][7:0] shadow_q;
  logic [NUM_REGS-1:0][7:0] active_q;
  logic                     pending_q;

  // Commit is evaluated before the write so a coinciding write re-arms pending
  // and the commit still copies the pre-write shadow contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      if (!IMMEDIATE && period_end_i && pending_q) begin
        active_q  <= shadow_q;
        pending_q <= 1'b0;
      end
      if (wr_en_i) begin
        shadow_q[wr_addr_i] <= wr_data_i;
        if (IMMEDIATE) begin
          active_q[wr_addr_i] <= wr_data_i;
        end else begin
          pending_q <= 1'b1;
        end
      end
    end
  end

  assign active_o  = active_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/pwm_reg_ctrl.sv
// Frame handshake FSM and reject counter in front of the PWM shadow register bank.
module pwm_reg_ctrl
  import pwm_reg_pkg::*;
#(
  parameter int unsigned MAX_ADDR  = 4,
  parameter bit          IMMEDIATE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frm_valid,
  output logic        frm_ready,
  input  logic [15:0] frm_data,
  input  logic        period_end,
  output logic [7:0]  en_out_lo,
  output logic [7:0]  en_out_hi,
  output logic [7:0]  en_pwm_lo,
  output logic [7:0]  en_pwm_hi,
  output logic [7:0]  pwm_duty,
  output logic        pending,
  output logic [7:0]  err_cnt
);

  state_e                   state_q;
  logic [15:0]              frame_q;
  logic [7:0]               err_cnt_q;
  logic [6:0]               frm_addr;
  logic                     addr_legal;
  logic                     bank_wr_en;
  logic [NUM_REGS-1:0][7:0] active;

  assign frm_addr   = frame_q[ADDR_MSB:ADDR_LSB];
  assign addr_legal = (frm_addr <= 7'(MAX_ADDR));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (frm_valid) begin
            frame_q <= frm_data;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (!frame_q[WR_BIT]) begin
            state_q <= IDLE;
          end else if (!addr_legal) begin
            if (err_cnt_q != '1) begin
              err_cnt_q <= err_cnt_q + 8'd1;
            end
            state_q <= IDLE;
          end else begin
            state_q <= STAGE;
          end
        end
        STAGE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frm_ready = (state_q == IDLE);

  // Legal addresses beyond the physical bank are accepted but have nowhere to land.
  assign bank_wr_en = (state_q == STAGE) && (frm_addr < 7'(NUM_REGS));

  pwm_shadow_bank #(
    .IMMEDIATE (IMMEDIATE)
  ) u_bank (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (bank_wr_en),
    .wr_addr_i    (frm_addr[BANK_AW-1:0]),
    .wr_data_i    (frame_q[7:0]),
    .period_end_i (period_end),
    .active_o     (active),
    .pending_o    (pending)
  );

  assign en_out_lo = active[ADDR_EN_OUT_LO];
  assign en_out_hi = active[ADDR_EN_OUT_HI];
  assign en_pwm_lo = active[ADDR_EN_PWM_LO];
  assign en_pwm_hi = active[ADDR_EN_PWM_HI];
  assign pwm_duty  = active[ADDR_DUTY];
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_pwm_reg_ctrl.sv
// Scoreboard bench for pwm_reg_ctrl: a reference model pushes expected snapshots, DUT samples pop them.
module tb_pwm_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frm_valid;
  logic        frm_ready;
  logic [15:0] frm_data;
  logic        period_end;
  logic [7:0]  en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, pwm_duty, err_cnt;
  logic        pending;

  always #5 clk = ~clk;

  pwm_reg_ctrl #(
    .MAX_ADDR  (4),
    .IMMEDIATE (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frm_valid  (frm_valid),
    .frm_ready  (frm_ready),
    .frm_data   (frm_data),
    .period_end (period_end),
    .en_out_lo  (en_out_lo),
    .en_out_hi  (en_out_hi),
    .en_pwm_lo  (en_pwm_lo),
    .en_pwm_hi  (en_pwm_hi),
    .pwm_duty   (pwm_duty),
    .pending    (pending),
    .err_cnt    (err_cnt)
  );

  typedef struct packed {
    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] r3;
    logic [7:0] r4;
    logic       pend;
    logic [7:0] err;
    logic       rdy;
  } snap_t;

  snap_t      sb_q[$];
  int         checks = 0;
  int         errors = 0;

  logic [7:0] m_shadow [5];
  logic [7:0] m_active [5];
  logic       m_pending;
  logic [7:0] m_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) begin
      m_shadow[i] = 8'h00;
      m_active[i] = 8'h00;
    end
    m_pending = 1'b0;
    m_err     = 8'h00;
  endfunction

  function automatic void model_commit();
    if (m_pending) begin
      for (int i = 0; i < 5; i++) m_active[i] = m_shadow[i];
      m_pending = 1'b0;
    end
  endfunction

  function automatic void model_write(input logic [15:0] f);
    int a;
    a = int'(f[14:8]);
    if (f[15]) begin
      if (a <= 4) begin
        m_shadow[a] = f[7:0];
        m_pending   = 1'b1;
      end else if (m_err != 8'hFF) begin
        m_err = m_err + 8'h01;
      end
    end
  endfunction

  function automatic void push_expected();
    snap_t s;
    s.r0   = m_active[0];
    s.r1   = m_active[1];
    s.r2   = m_active[2];
    s.r3   = m_active[3];
    s.r4   = m_active[4];
    s.pend = m_pending;
    s.err  = m_err;
    s.rdy  = 1'b1;
    sb_q.push_back(s);
  endfunction

  function automatic snap_t get_obs();
    snap_t s;
    s.r0   = en_out_lo;
    s.r1   = en_out_hi;
    s.r2   = en_pwm_lo;
    s.r3   = en_pwm_hi;
    s.r4   = pwm_duty;
    s.pend = pending;
    s.err  = err_cnt;
    s.rdy  = frm_ready;
    return s;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!frm_ready && n < 20) begin
      step();
      n++;
    end
    if (!frm_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: frm_ready=%b required 1", tag, frm_ready);
    end
  endtask

  // Full handshake; pe_at_stage raises period_end during the STAGE cycle.
  task automatic send_frame(input logic [15:0] f, input bit pe_at_stage);
    wait_ready("send");
    frm_valid = 1'b1;
    frm_data  = f;
    step();
    frm_valid = 1'b0;
    step();
    if (f[15] && (f[14:8] <= 7'd4)) begin
      period_end = pe_at_stage;
      step();
      period_end = 1'b0;
      if (pe_at_stage) model_commit();
    end
    model_write(f);
  endtask

  task automatic pulse_period_end();
    period_end = 1'b1;
    step();
    period_end = 1'b0;
    model_commit();
  endtask

  task automatic test_reset();
    snap_t exp, obs;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
    push_expected();
    exp = sb_q.pop_front();
    obs = get_obs();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_stage_commit();
    snap_t exp, obs;
    send_frame(16'h80FF, 1'b0);
    push_expected();
    step();
    step();
    exp = sb_q.pop_front();
    obs = get_obs();
    checks++;
    if (obs !== exp || en_out_lo !== 8'h00 || pending !== 1'b1) begin
      errors++;
      $display("FAIL staged_not_active: got %h expected %h", obs, exp);
    end
    pulse_period_end();
    push_expected();
    exp = sb_q.pop_front();
    obs = get_obs();
    checks++;
    if (obs !== exp || en_out_lo !== 8'hFF) begin
      errors++;
      $display("FAIL commit_addr0: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_last_wins();
    snap_t exp, obs;
    send_frame(16'h8455, 1'b0);
    send_frame(16'h84AA, 1'b0);
    pulse_period_end();
    push_expected();
    exp = sb_q.pop_front();
    obs = get_obs();
    checks++;
    if (obs !== exp || pwm_duty !== 8'hAA) begin
      errors++;
      $display("FAIL last_write_wins: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_errors();
    snap_t exp, obs;
    send_frame(16'h8A12, 1'b0);
    push_expected();
    exp = sb_q.pop_front();
    obs = get_obs();
    checks++;
    if (obs !== exp || err_cnt !== 8'h01) begin
      errors++;
      $display("FAIL reject_first: got %h expected %h", obs, exp);
    end
    pulse_period_end();
    push_expected();
    exp = sb_q.pop_front();
    obs = get_obs();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reject_no_write: got %h expected %h", obs, exp);
    end
    for (int i = 0; i < 299; i++) send_frame(16'h8A12, 1'b0);
    push_expected();
    exp = sb_q.pop_front();
    obs = get_obs();
    checks++;
    if (obs !== exp || err_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL err_saturate: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_read();
    snap_t exp, obs;
    wait_ready("read");
    frm_valid = 1'b1;
    frm_data  = 16'h0133;
    step();
    frm_valid = 1'b0;
    checks++;
    if (frm_ready !== 1'b0) begin
      errors++;
      $display("FAIL read_busy: frm_ready=%b required 0", frm_ready);
    end
    step();
    checks++;
    if (frm_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_ready_back: frm_ready=%b required 1", frm_ready);
    end
    model_write(16'h0133);
    pulse_period_end();
    push_expected();
    exp = sb_q.pop_front();
    obs = get_obs();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL read_no_effect: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_stage_commit_overlap();
    snap_t exp, obs;
    send_frame(16'h8007, 1'b0);
    send_frame(16'h8203, 1'b1);
    push_expected();
    exp = sb_q.pop_front();
    obs = get_obs();
    checks++;
    if (obs !== exp || en_out_lo !== 8'h07 || en_pwm_lo !== 8'h00 || pending !== 1'b1) begin
      errors++;
      $display("FAIL overlap_commit: got %h expected %h", obs, exp);
    end
    pulse_period_end();
    push_expected();
    exp = sb_q.pop_front();
    obs = get_obs();
    checks++;
    if (obs !== exp || en_pwm_lo !== 8'h03) begin
      errors++;
      $display("FAIL overlap_next_commit: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    snap_t exp, obs;
    wait_ready("b2b");
    frm_valid = 1'b1;
    frm_data  = 16'h8111;
    step();
    frm_data  = 16'h8322;
    step();
    step();
    checks++;
    if (frm_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_t3: frm_ready=%b required 1", frm_ready);
    end
    step();
    frm_valid = 1'b0;
    step();
    step();
    model_write(16'h8111);
    model_write(16'h8322);
    pulse_period_end();
    push_expected();
    exp = sb_q.pop_front();
    obs = get_obs();
    checks++;
    if (obs !== exp || en_out_hi !== 8'h11 || en_pwm_hi !== 8'h22) begin
      errors++;
      $display("FAIL b2b_held_valid: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_reset_mid_frame();
    snap_t exp, obs;
    wait_ready("rstmid");
    frm_valid = 1'b1;
    frm_data  = 16'h8177;
    step();
    frm_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    push_expected();
    exp = sb_q.pop_front();
    obs = get_obs();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_in_check: got %h expected %h", obs, exp);
    end
    step();
    pulse_period_end();
    push_expected();
    exp = sb_q.pop_front();
    obs = get_obs();
    checks++;
    if (obs !== exp || en_out_hi !== 8'h00) begin
      errors++;
      $display("FAIL reset_dropped_frame: got %h expected %h", obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    frm_valid  = 1'b0;
    frm_data   = 16'h0000;
    period_end = 1'b0;
    model_reset();
    test_reset();
    test_stage_commit();
    test_last_wins();
    test_errors();
    test_read();
    test_stage_commit_overlap();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
